uart_rx_path: RTL and testbench
===============================

# uart_rx_path

Receive-side UART datapath with its two baud tick generators. It produces a 1x-baud tick for the sibling transmitter and a 16x-oversample tick for the receiver, and deserialises 8N1 frames from the RX pin into a byte with a run/done handshake. It sits between the board RX pin and the top-level rx/tx sequencing logic.

## Interface
Parameters:
- CLK_HZ, 12_000_000, CLKIN frequency in Hz.
- BAUD, 9600, line rate.
- OVERSAMPLE, 16, rx ticks per bit. Fixed at 16; other values are unsupported.

Ports:
- CLKIN  in  1  single system clock; all logic runs on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- rx  in  1  serial line, asynchronous to CLKIN, idle high.
- run  in  1  enables reception; low aborts or clears the receiver.
- baud_tx_tick  out  1  one-CLKIN-cycle pulse at BAUD.
- baud_rx_tick  out  1  one-CLKIN-cycle pulse at BAUD*16.
- data  out  8  last correctly received byte.
- done  out  1  byte available; held until run falls.
- frame_err  out  1  last frame had stop bit = 0.

## Operation
Tick generators:
- TX_DIV = round(CLK_HZ/BAUD), which is 1250 at the defaults.
- RX_DIV = round(CLK_HZ/(BAUD*16)), which is 78 at the defaults.
- Each generator has a counter that runs 0..DIV-1 and wraps to 0.
- The tick is high exactly during the cycle the counter equals DIV-1.
- The generators free-run regardless of run.

Input synchroniser:
- rx passes through a 2-flop synchroniser to give rx_s.
- Both flops reset to 1.

Receiver FSM, advanced only on baud_rx_tick cycles except where stated. It has a 4-bit tick counter, a 3-bit bit counter and an 8-bit shift register.
- IDLE: on a tick with run=1 and rx_s=0, go to START with cnt=0.
- START: cnt increments each tick. At cnt=7 (mid start bit):
  - rx_s=0: go to DATA with cnt=0 and bitcnt=0.
  - rx_s=1: treat as a glitch and return to IDLE.
- DATA: at cnt=15, shift rx_s in from the MSB end (LSB arrives first, ends in bit 0) and reset cnt to 0. After bitcnt=7, go to STOP.
- STOP: at cnt=15:
  - rx_s=1: load data from the shift register, set done=1 and frame_err=0, go to DONE.
  - rx_s=0: set frame_err=1, leave data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: return to IDLE on a tick with rx_s=1.
- DONE: hold done and data. Leave only via run=0.
- run=0, checked every CLKIN cycle in any state:
  - next state is IDLE and done clears;
  - data and frame_err keep their values;
  - the shift register contents are don't-care.
- A new start clears frame_err when START accepts at cnt=7.

## Timing
- Reset values:
  - tick counters 0, both ticks 0;
  - state IDLE, data 8'h00, done 0, frame_err 0;
  - synchroniser flops 1.
- Start detection latency: up to 2 CLKIN cycles of sync plus up to one rx tick period.
- Counting from the detecting tick as tick 0:
  - start verify on tick 7;
  - data bit i sampled on tick 7+16(i+1);
  - stop sampled on tick 151.
- done, data and frame_err are registered and update the CLKIN cycle after the sampling tick.
- done stays high until the first CLKIN edge at which run=0 is registered. A done/run handshake is therefore never lost, even though the top level samples it on rx ticks.
- Reset asserted mid-frame returns every register to its reset value immediately (asynchronous clear).
- rx activity while in DONE is ignored. The next frame is received only after run goes low, then high, and a fresh start bit appears.

## Structure
- Package uart_pkg holds:
  - the rx FSM state enum (IDLE, START, DATA, STOP, DONE, WAIT_HIGH);
  - the OVERSAMPLE and MID_SAMPLE=7 constants;
  - a divisor-rounding function.
- Sub-module baud_tick_gen (parameter DIV) is instantiated twice, for tx and rx.
- Receiver FSM and synchroniser live in the top of the block.

## Test plan
- Reset and tick rates: assert RST, then release. All outputs read 0, baud_tx_tick pulses every 1250 cycles and baud_rx_tick every 78 cycles, each one cycle wide.
- Good frame: run=1, drive 8N1 0xA5 at 9600 baud. done rises about 152 rx ticks after the start edge, data=8'hA5 and frame_err=0. done holds until run=0, then clears.
- Framing error: send 0x3C with the stop bit low. frame_err=1, done stays 0, data keeps its previous value. The next good 0x5A gives data=8'h5A and frame_err=0.
- Start glitch: drive rx low for 4 rx ticks, then high. No reception occurs, state returns to IDLE, and a following good 0x81 is received correctly.
- Abort: drop run midway through the data bits of 0xFF. done=0 and data is unchanged. With run=1, the next frame 0x00 is received as 8'h00.
- Reset mid-frame: assert RST during bit 4. Outputs immediately return to reset values, and a subsequent frame 0x96 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver oversampling ratio and the tick (counted from the detecting
  // tick) on which the start bit is re-checked at its centre.
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    DONE      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  // Integer division rounded to nearest, used to derive tick divisors.
  function automatic int div_round(input int num, input int den);
    return (num + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_rx_path_if.sv
// Pin/handshake bundle between the UART receive path and its sequencer.
// Latency: n/a (wires only).
// Backpressure: done is held until the sequencer drops run.
interface uart_rx_path_if;

  logic       rx;
  logic       run;
  logic       baud_tx_tick;
  logic       baud_rx_tick;
  logic [7:0] data;
  logic       done;
  logic       frame_err;

  // Sequencer side: drives the line and run, consumes ticks and results.
  modport master (
    output rx,
    output run,
    input  baud_tx_tick,
    input  baud_rx_tick,
    input  data,
    input  done,
    input  frame_err
  );

  // Receive path side.
  modport slave (
    input  rx,
    input  run,
    output baud_tx_tick,
    output baud_rx_tick,
    output data,
    output done,
    output frame_err
  );

endinterface

// File: rtl/uart_rx_path_baud_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// Latency: tick is high while the counter sits at DIV-1.
// Backpressure: none; runs continuously out of reset.
module baud_tick_gen #(
  parameter int DIV = 2
) (
  input  logic CLKIN,
  input  logic RST,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_path.sv
// UART 8N1 receiver with 1x (tx) and 16x (rx) baud tick generators.
// Latency: done/data/frame_err register one cycle after the stop-bit sampling tick.
// Backpressure: done and data hold until run is seen low; line activity meanwhile is ignored.
module uart_rx_path #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic          CLKIN,
  input  logic          RST,
  uart_rx_path_if.slave bus
);

  import uart_pkg::*;

  localparam int TX_DIV = div_round(CLK_HZ, BAUD);
  localparam int RX_DIV = div_round(CLK_HZ, BAUD * OVERSAMPLE);

  // The detecting tick loads cnt=0, so the counter reaches MID_SAMPLE on
  // the start-bit centre tick; each data/stop bit then spans a full
  // 16-tick wrap of the 4-bit counter.
  localparam logic [3:0] MID_CNT = 4'(MID_SAMPLE);
  localparam logic [3:0] BIT_END = 4'(uart_pkg::OVERSAMPLE - 1);

  logic tx_tick;
  logic rx_tick;

  baud_tick_gen #(.DIV(TX_DIV)) u_tx_tick (
    .CLKIN (CLKIN),
    .RST   (RST),
    .tick  (tx_tick)
  );

  baud_tick_gen #(.DIV(RX_DIV)) u_rx_tick (
    .CLKIN (CLKIN),
    .RST   (RST),
    .tick  (rx_tick)
  );

  assign bus.baud_tx_tick = tx_tick;
  assign bus.baud_rx_tick = rx_tick;

  logic rx_meta;
  logic rx_s;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  rx_state_t  state,     state_nxt;
  logic [3:0] cnt,       cnt_nxt;
  logic [2:0] bitcnt,    bitcnt_nxt;
  logic [7:0] shreg,     shreg_nxt;
  logic [7:0] data_q,    data_nxt;
  logic       done_q,    done_nxt;
  logic       ferr_q,    ferr_nxt;

  // Receiver state and datapath registers.
  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      bitcnt <= bitcnt_nxt;
      shreg  <= shreg_nxt;
      data_q <= data_nxt;
      done_q <= done_nxt;
      ferr_q <= ferr_nxt;
    end
  end

  // Next-state logic: run=0 overrides every cycle, otherwise advance on rx ticks.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    data_nxt   = data_q;
    done_nxt   = done_q;
    ferr_nxt   = ferr_q;

    if (!bus.run) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
    end else if (rx_tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            cnt_nxt   = '0;
          end
        end

        START: begin
          cnt_nxt = cnt + 4'd1;
          if ((cnt + 4'd1) == MID_CNT) begin
            if (!rx_s) begin
              state_nxt  = DATA;
              cnt_nxt    = '0;
              bitcnt_nxt = '0;
              ferr_nxt   = 1'b0;
            end else begin
              // Line went back high before mid-bit: a glitch, not a start.
              state_nxt = IDLE;
            end
          end
        end

        DATA: begin
          if (cnt == BIT_END) begin
            cnt_nxt   = '0;
            shreg_nxt = {rx_s, shreg[7:1]};
            if (bitcnt == 3'd7) begin
              state_nxt = STOP;
            end else begin
              bitcnt_nxt = bitcnt + 3'd1;
            end
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end

        STOP: begin
          if (cnt == BIT_END) begin
            cnt_nxt = '0;
            if (rx_s) begin
              data_nxt  = shreg;
              done_nxt  = 1'b1;
              ferr_nxt  = 1'b0;
              state_nxt = DONE;
            end else begin
              // Bad stop bit: keep the previous byte, wait for the line to idle.
              ferr_nxt  = 1'b1;
              state_nxt = WAIT_HIGH;
            end
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state_nxt = IDLE;
          end
        end

        DONE: begin
          // Parked until the sequencer drops run.
          state_nxt = DONE;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.done      = done_q;
  assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_path.sv
// Self-checking bench for uart_rx_path: tick rates, frames, errors, abort, reset.
// Latency: reference derives done timing from the tick schedule of the line rate.
// Backpressure: bench performs the run/done handshake after each good frame.
module tb_uart_rx_path;

  // Scaled clock so frames are short: 16 rx ticks of 10 clocks per bit.
  localparam int CLK_HZ_T = 1_536_000;
  localparam int BAUD_T   = 9600;
  localparam int BIT      = (CLK_HZ_T + BAUD_T / 2) / BAUD_T;              // 160
  localparam int RXD      = (CLK_HZ_T + BAUD_T * 8) / (BAUD_T * 16);       // 10

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_path_if m ();
  uart_rx_path_if bd ();

  uart_rx_path #(.CLK_HZ(CLK_HZ_T), .BAUD(BAUD_T), .OVERSAMPLE(16)) dut (
    .CLKIN (clk),
    .RST   (rst),
    .bus   (m.slave)
  );

  uart_rx_path dut_def (
    .CLKIN (clk),
    .RST   (rst),
    .bus   (bd.slave)
  );

  assign bd.rx  = 1'b1;
  assign bd.run = 1'b0;

  always #5 clk = ~clk;

  // Clock edges since reset release.
  int cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Record the edge on which done last rose.
  int   rise_cyc  = -1;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (m.done === 1'b1 && done_prev !== 1'b1) rise_cyc = cyc;
    done_prev = m.done;
  end

  logic [3:0] tk;
  assign tk = {bd.baud_rx_tick, bd.baud_tx_tick, m.baud_rx_tick, m.baud_tx_tick};

  int npass = 0;
  int nchk  = 0;

  logic [7:0] exp_data = 8'h00;
  logic       exp_done = 1'b0;
  logic       exp_ferr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Line-level reference: a good stop bit delivers the byte, a bad one flags it.
  task automatic model_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      exp_data = b;
      exp_done = 1'b1;
      exp_ferr = 1'b0;
    end else begin
      exp_ferr = 1'b1;
    end
  endtask

  // Start edge driven after edge s; rx_s low from edge s+2, so the first rx tick
  // edge (a multiple of RXD) at or after s+3 detects it; stop sampled 151 ticks on.
  function automatic int exp_rise(input int s);
    return ((s + 3 + RXD - 1) / RXD) * RXD + (7 + 16 * 9) * RXD;
  endfunction

  task automatic measure(input int sel, output int period, output int width);
    int n;
    period = -1;
    width  = -1;
    n = 0;
    while (tk[sel] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) return;
    width = 0;
    while (tk[sel] === 1'b1 && width < 3000) begin @(negedge clk); width++; end
    n = 0;
    while (tk[sel] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n < 3000) period = width + n;
  endtask

  // evt_kind: 0 none, 1 drop run mid data bit evt_bit, 2 assert reset there.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int evt_kind, input int evt_bit, output int start_cyc);
    @(negedge clk);
    m.rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      m.rx = b[i];
      if (evt_kind != 0 && i == evt_bit) begin
        repeat (BIT / 2) @(negedge clk);
        if (evt_kind == 1) begin
          m.run = 1'b0;
        end else begin
          rst = 1'b1;
          #1;
          chk("rstmid_data", m.data, 8'h00);
          chk("rstmid_done", m.done, 1'b0);
          chk("rstmid_ferr", m.frame_err, 1'b0);
          chk("rstmid_ticks", {m.baud_tx_tick, m.baud_rx_tick}, 2'b00);
          m.rx = 1'b1;
          return;
        end
        repeat (BIT - BIT / 2) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
    m.rx = stop_bit;
    repeat (BIT) @(negedge clk);
    m.rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic rx_frame(input string tag, input logic [7:0] b, input logic stop_bit);
    int s;
    send_frame(b, stop_bit, 0, 0, s);
    model_frame(b, stop_bit);
    chk({tag, "_data"}, m.data, exp_data);
    chk({tag, "_done"}, m.done, exp_done);
    chk({tag, "_ferr"}, m.frame_err, exp_ferr);
    if (stop_bit) chk({tag, "_lat"}, rise_cyc, exp_rise(s));
  endtask

  task automatic handshake(input string tag);
    m.run = 1'b0;
    @(negedge clk);
    exp_done = 1'b0;
    chk({tag, "_hs_done"}, m.done, exp_done);
    chk({tag, "_hs_data"}, m.data, exp_data);
    m.run = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int per, wid, s;
    logic [7:0] rb;
    logic       rs;

    m.rx  = 1'b1;
    m.run = 1'b0;
    rst   = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_data", m.data, 8'h00);
    chk("rst_done", m.done, 1'b0);
    chk("rst_ferr", m.frame_err, 1'b0);
    chk("rst_txtick", m.baud_tx_tick, 1'b0);
    chk("rst_rxtick", m.baud_rx_tick, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out", {m.done, m.frame_err, m.data}, 10'h000);

    measure(0, per, wid); chk("tx_period", per, BIT);  chk("tx_width", wid, 1);
    measure(1, per, wid); chk("rx_period", per, RXD);  chk("rx_width", wid, 1);
    measure(2, per, wid); chk("def_tx_period", per, 1250); chk("def_tx_width", wid, 1);
    measure(3, per, wid); chk("def_rx_period", per, 78);   chk("def_rx_width", wid, 1);

    m.run = 1'b1;
    repeat (5) @(negedge clk);

    // Good frame, hold, and ignored traffic while done is pending.
    rx_frame("a5", 8'hA5, 1'b1);
    repeat (100) @(negedge clk);
    chk("a5_hold_done", m.done, 1'b1);
    send_frame(8'h3F, 1'b1, 0, 0, s);
    chk("ign_data", m.data, exp_data);
    chk("ign_done", m.done, 1'b1);
    handshake("a5");

    // Framing error keeps the byte, next good frame clears the flag.
    rx_frame("3c_bad", 8'h3C, 1'b0);
    rx_frame("5a", 8'h5A, 1'b1);
    handshake("5a");

    // Start glitch of four rx ticks.
    @(negedge clk);
    m.rx = 1'b0;
    repeat (4 * RXD) @(negedge clk);
    m.rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("glitch_out", {m.done, m.frame_err, m.data}, {exp_done, exp_ferr, exp_data});
    rx_frame("81", 8'h81, 1'b1);
    handshake("81");

    // Abort mid data bits.
    send_frame(8'hFF, 1'b1, 1, 3, s);
    chk("abort_done", m.done, 1'b0);
    chk("abort_data", m.data, exp_data);
    m.run = 1'b1;
    repeat (5) @(negedge clk);
    rx_frame("00", 8'h00, 1'b1);
    handshake("00");

    // Random bytes with occasional bad stop bits.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, BIT)) @(negedge clk);
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      rx_frame("rnd", rb, rs);
      if (rs) handshake("rnd");
    end

    // Reset in the middle of data bit 4.
    rx_frame("7e", 8'h7E, 1'b1);
    handshake("7e");
    send_frame(8'h96, 1'b1, 2, 4, s);
    exp_data = 8'h00;
    exp_done = 1'b0;
    exp_ferr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);
    chk("after_rst_out", {m.done, m.frame_err, m.data}, {exp_done, exp_ferr, exp_data});
    m.run = 1'b1;
    repeat (5) @(negedge clk);
    rx_frame("96", 8'h96, 1'b1);
    handshake("96");

    chk("def_idle", {bd.done, bd.frame_err, bd.data}, 10'h000);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
